// File: rtl/thread_scheduler.sv
// thread_scheduler: hands a frame of job IDs to a thread array.
// Each free thread gets the next job, picked round-robin from the last grant.
// frame_done pulses once all jobs are issued and every thread has reported done.
module thread_scheduler #(
  parameter int unsigned N_THREADS = 16,
  parameter int unsigned JOB_W     = 20,
  parameter int unsigned TID_W     = $clog2(N_THREADS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [JOB_W-1:0]     job_count,
  output logic [N_THREADS-1:0] thread_start,
  output logic [JOB_W-1:0]     thread_job,
  input  logic [N_THREADS-1:0] thread_done,
  output logic [N_THREADS-1:0] active_mask,
  output logic [JOB_W-1:0]     jobs_issued,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]           state, state_n;
  logic [JOB_W-1:0]     job_total, job_total_n;
  logic [JOB_W-1:0]     jobs_issued_n;
  logic [TID_W-1:0]     ptr, ptr_n;
  logic [N_THREADS-1:0] mask_n;
  logic [N_THREADS-1:0] thread_start_n;
  logic [JOB_W-1:0]     thread_job_n;
  logic                 busy_n;
  logic                 frame_done_n;

  logic                 grant_vld;
  logic [TID_W-1:0]     grant_idx;
  int unsigned          cand;

  // Round-robin search: first idle thread at or after ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned i = 0; i < N_THREADS; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N_THREADS) cand = cand - N_THREADS;
      if (!grant_vld && !active_mask[TID_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = TID_W'(cand);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n        = state;
    job_total_n    = job_total;
    jobs_issued_n  = jobs_issued;
    ptr_n          = ptr;
    mask_n         = active_mask & ~thread_done;
    thread_start_n = '0;
    thread_job_n   = thread_job;
    frame_done_n   = 1'b0;

    case (state)
      S_IDLE: begin
        // busy is still high during the frame_done pulse; start waits it out
        if (start && !busy) begin
          job_total_n   = job_count;
          jobs_issued_n = '0;
          ptr_n         = '0;
          state_n       = (job_count == '0) ? S_DONE : S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (jobs_issued == job_total) begin
          state_n = S_DRAIN;
        end else if (grant_vld) begin
          thread_start_n    = N_THREADS'(1) << grant_idx;
          thread_job_n      = jobs_issued;
          mask_n[grant_idx] = 1'b1;
          jobs_issued_n     = jobs_issued + JOB_W'(1);
          ptr_n = (grant_idx == TID_W'(N_THREADS - 1)) ? '0 : grant_idx + TID_W'(1);
          if (jobs_issued_n == job_total) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (active_mask == '0) state_n = S_DONE;
      end
      S_DONE: begin
        frame_done_n = 1'b1;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // busy covers the frame_done cycle so it drops the cycle after
    busy_n = (state_n != S_IDLE) || (state == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      job_total    <= '0;
      jobs_issued  <= '0;
      ptr          <= '0;
      active_mask  <= '0;
      thread_start <= '0;
      thread_job   <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_n;
      job_total    <= job_total_n;
      jobs_issued  <= jobs_issued_n;
      ptr          <= ptr_n;
      active_mask  <= mask_n;
      thread_start <= thread_start_n;
      thread_job   <= thread_job_n;
      busy         <= busy_n;
      frame_done   <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed testbench for thread_scheduler (16 threads, 20-bit job IDs).
module tb_thread_scheduler;

  localparam int unsigned NT = 16;
  localparam int unsigned JW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [JW-1:0] job_count;
  logic [NT-1:0] thread_start;
  logic [JW-1:0] thread_job;
  logic [NT-1:0] thread_done;
  logic [NT-1:0] active_mask;
  logic [JW-1:0] jobs_issued;
  logic          busy;
  logic          frame_done;

  int tests = 0;
  int fails = 0;

  thread_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .job_count(job_count),
    .thread_start(thread_start), .thread_job(thread_job),
    .thread_done(thread_done), .active_mask(active_mask),
    .jobs_issued(jobs_issued), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs read afterwards belong to the new cycle.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; job_count = '0; thread_done = '0;
    tick; tick;
    tests++; if (thread_start !== '0) begin fails++; $display("FAIL reset_thread_start got %h exp 0", thread_start); end
    tests++; if (thread_job !== '0) begin fails++; $display("FAIL reset_thread_job got %h exp 0", thread_job); end
    tests++; if (active_mask !== '0) begin fails++; $display("FAIL reset_active_mask got %h exp 0", active_mask); end
    tests++; if (jobs_issued !== '0) begin fails++; $display("FAIL reset_jobs_issued got %h exp 0", jobs_issued); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    rst = 1'b0;
    tick;
  endtask

  // Four jobs, each thread finishes 3 cycles after its start.
  task automatic test_basic;
    logic [NT-1:0] es;
    int nfd;
    int fd_at;
    nfd = 0; fd_at = -1;
    start = 1'b1; job_count = JW'(4);
    for (int r = 1; r <= 14; r++) begin
      tick;
      start = 1'b0;
      thread_done = (r >= 5 && r <= 8) ? NT'(1) << (r - 5) : '0;
      es = (r >= 2 && r <= 5) ? NT'(1) << (r - 2) : '0;
      tests++; if (thread_start !== es) begin fails++; $display("FAIL basic_start r=%0d got %h exp %h", r, thread_start, es); end
      if (r >= 2 && r <= 5) begin
        tests++; if (thread_job !== JW'(r - 2)) begin fails++; $display("FAIL basic_job r=%0d got %0d exp %0d", r, thread_job, r - 2); end
      end
      if (r == 5) begin
        tests++; if (active_mask !== 16'h000F) begin fails++; $display("FAIL basic_mask got %h exp 000f", active_mask); end
      end
      if (r == 11) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_fd got %b exp 1", busy); end
      end
      if (r == 12) begin
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after got %b exp 0", busy); end
      end
      if (frame_done === 1'b1) begin nfd++; fd_at = r; end
    end
    thread_done = '0;
    tests++; if (nfd != 1) begin fails++; $display("FAIL basic_fd_count got %0d exp 1", nfd); end
    tests++; if (fd_at != 11) begin fails++; $display("FAIL basic_fd_cycle got %0d exp 11", fd_at); end
  endtask

  // Twenty jobs with all threads busy; dones free specific threads.
  task automatic test_stall;
    logic [NT-1:0] es;
    logic [JW-1:0] ej;
    start = 1'b1; job_count = JW'(20);
    for (int r = 1; r <= 40; r++) begin
      tick;
      start = 1'b0;
      case (r)
        20:      thread_done = 16'h0020;
        24:      thread_done = 16'h0204;
        28:      thread_done = 16'h0001;
        32:      thread_done = 16'hFFFF;
        default: thread_done = '0;
      endcase
      ej = '0;
      if (r >= 2 && r <= 17) begin es = NT'(1) << (r - 2); ej = JW'(r - 2); end
      else if (r == 22) begin es = 16'h0020; ej = JW'(16); end
      else if (r == 26) begin es = 16'h0200; ej = JW'(17); end
      else if (r == 27) begin es = 16'h0004; ej = JW'(18); end
      else if (r == 30) begin es = 16'h0001; ej = JW'(19); end
      else es = '0;
      tests++; if (thread_start !== es) begin fails++; $display("FAIL stall_start r=%0d got %h exp %h", r, thread_start, es); end
      if (es != '0) begin
        tests++; if (thread_job !== ej) begin fails++; $display("FAIL stall_job r=%0d got %0d exp %0d", r, thread_job, ej); end
      end
      if (r == 20) begin
        tests++; if (jobs_issued !== JW'(16)) begin fails++; $display("FAIL stall_issued got %0d exp 16", jobs_issued); end
        tests++; if (active_mask !== 16'hFFFF) begin fails++; $display("FAIL stall_mask got %h exp ffff", active_mask); end
      end
      if (r == 31) begin
        tests++; if (jobs_issued !== JW'(20)) begin fails++; $display("FAIL stall_issued_end got %0d exp 20", jobs_issued); end
      end
      tests++; if (frame_done !== (r == 35)) begin fails++; $display("FAIL stall_fd r=%0d got %b exp %b", r, frame_done, r == 35); end
      if (r == 36) begin
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stall_busy_after got %b exp 0", busy); end
      end
    end
  endtask

  // Empty frame: straight to done.
  task automatic test_zero;
    int nbusy;
    int nfd;
    nbusy = 0; nfd = 0;
    start = 1'b1; job_count = '0;
    for (int r = 1; r <= 5; r++) begin
      tick;
      start = 1'b0;
      if (busy === 1'b1) nbusy++;
      if (frame_done === 1'b1) nfd++;
      tests++; if (thread_start !== '0) begin fails++; $display("FAIL zero_start r=%0d got %h exp 0", r, thread_start); end
    end
    tests++; if (nbusy != 2) begin fails++; $display("FAIL zero_busy_cycles got %0d exp 2", nbusy); end
    tests++; if (nfd != 1) begin fails++; $display("FAIL zero_fd_count got %0d exp 1", nfd); end
  endtask

  // Reset after seven grants, then a fresh three-job frame.
  task automatic test_reset_mid;
    logic [NT-1:0] es;
    int nfd;
    nfd = 0;
    start = 1'b1; job_count = JW'(50);
    for (int r = 1; r <= 8; r++) begin
      tick;
      start = 1'b0;
    end
    tests++; if (jobs_issued !== JW'(7)) begin fails++; $display("FAIL rmid_issued got %0d exp 7", jobs_issued); end
    tests++; if (thread_start !== 16'h0040) begin fails++; $display("FAIL rmid_start got %h exp 0040", thread_start); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests++; if (thread_start !== '0) begin fails++; $display("FAIL rmid_thread_start got %h exp 0", thread_start); end
    tests++; if (thread_job !== '0) begin fails++; $display("FAIL rmid_thread_job got %h exp 0", thread_job); end
    tests++; if (active_mask !== '0) begin fails++; $display("FAIL rmid_mask got %h exp 0", active_mask); end
    tests++; if (jobs_issued !== '0) begin fails++; $display("FAIL rmid_jobs_issued got %h exp 0", jobs_issued); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b exp 0", busy); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rmid_fd got %b exp 0", frame_done); end
    thread_done = 16'h007F;
    tick;
    thread_done = '0;
    tests++; if (active_mask !== '0) begin fails++; $display("FAIL rmid_late_done_mask got %h exp 0", active_mask); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_late_done_busy got %b exp 0", busy); end
    start = 1'b1; job_count = JW'(3);
    for (int r = 1; r <= 12; r++) begin
      tick;
      start = 1'b0;
      thread_done = (r == 6) ? 16'h0007 : '0;
      es = (r >= 2 && r <= 4) ? NT'(1) << (r - 2) : '0;
      tests++; if (thread_start !== es) begin fails++; $display("FAIL rmid2_start r=%0d got %h exp %h", r, thread_start, es); end
      if (r >= 2 && r <= 4) begin
        tests++; if (thread_job !== JW'(r - 2)) begin fails++; $display("FAIL rmid2_job r=%0d got %0d exp %0d", r, thread_job, r - 2); end
      end
      if (frame_done === 1'b1) nfd++;
    end
    thread_done = '0;
    tests++; if (nfd != 1) begin fails++; $display("FAIL rmid2_fd_count got %0d exp 1", nfd); end
  endtask

  // Done for an idle thread and a start mid-frame are both ignored.
  task automatic test_spurious;
    int nst;
    int nfd;
    nst = 0; nfd = 0;
    start = 1'b1; job_count = JW'(2);
    for (int r = 1; r <= 14; r++) begin
      tick;
      start = (r == 4);
      job_count = (r == 4) ? JW'(99) : JW'(2);
      thread_done = (r == 4) ? 16'h1000 : (r == 6) ? 16'h0003 : '0;
      if (r == 5) begin
        tests++; if (active_mask !== 16'h0003) begin fails++; $display("FAIL spur_mask got %h exp 0003", active_mask); end
        tests++; if (jobs_issued !== JW'(2)) begin fails++; $display("FAIL spur_issued got %0d exp 2", jobs_issued); end
      end
      if (thread_start !== '0) nst++;
      if (frame_done === 1'b1) nfd++;
    end
    start = 1'b0; thread_done = '0;
    tests++; if (nst != 2) begin fails++; $display("FAIL spur_start_count got %0d exp 2", nst); end
    tests++; if (nfd != 1) begin fails++; $display("FAIL spur_fd_count got %0d exp 1", nfd); end
    tests++; if (jobs_issued !== JW'(2)) begin fails++; $display("FAIL spur_issued_end got %0d exp 2", jobs_issued); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL spur_busy_end got %b exp 0", busy); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_zero;
    test_reset_mid;
    test_spurious;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/thread_scheduler.md
Name: thread_scheduler

Overview:
- Dispatches a frame of work items (job IDs 0..job_count-1, e.g. pixel indices) across the parallel thread array.
- Tracks which threads are busy and hands each free thread the next job using round-robin arbitration.
- Signals the end of the frame once every job has been issued and every thread has reported done.
- Sits between the frame control logic and the `thread_instantiation` array, driving each thread's start input and collecting its done output.

Parameters:
- N_THREADS, 16, number of worker threads; must be ≥2.
- JOB_W, 20, width of job IDs and job counter.
- TID_W, $clog2(N_THREADS), width of the thread index.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  frame start pulse; honoured only in IDLE.
- job_count  input  JOB_W  jobs in frame; sampled when start is accepted.
- thread_start  output  N_THREADS  one-hot, one-cycle start pulse to a thread (registered).
- thread_job  output  JOB_W  job ID for the thread pulsed on thread_start (registered).
- thread_done  input  N_THREADS  per-thread one-cycle completion pulse; any number may be high together.
- active_mask  output  N_THREADS  registered busy bit per thread.
- jobs_issued  output  JOB_W  jobs dispatched so far this frame.
- busy  output  1  high whenever state ≠ IDLE.
- frame_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset values:
  - state = IDLE.
  - thread_start = 0, thread_job = 0, active_mask = 0, jobs_issued = 0.
  - busy = 0, frame_done = 0.
  - Round-robin pointer = 0.
- Reset mid-frame:
  - Aborts immediately to the reset values.
  - thread_done pulses arriving afterwards are ignored.
- States:
  - IDLE: start=1 → latch job_count, clear jobs_issued, set pointer=0. Next state is DISPATCH, or DONE if job_count=0.
  - DISPATCH: at most one grant per cycle. When jobs_issued reaches job_count → DRAIN.
  - DRAIN: no grants. When active_mask=0 → DONE.
  - DONE: frame_done=1 for this one cycle → IDLE.
- Grant rule in DISPATCH:
  - Eligible threads are those with active_mask bit = 0, using the registered mask.
  - Grant the first eligible index at or after the pointer, wrapping modulo N_THREADS.
  - On a grant to thread k in cycle c:
    - thread_start[k]=1 and thread_job=jobs_issued are visible in cycle c+1.
    - active_mask[k] is set in cycle c+1.
    - jobs_issued increments.
    - pointer becomes (k+1) mod N_THREADS.
  - If no thread is eligible: no grant, and all state holds.
- Latency:
  - Start sampled in cycle t → first thread_start in cycle t+2.
  - thread_done[i] in cycle c → bit i clears in c+1 → thread i can be granted in c+1 → its thread_start in c+2.
  - Done and grant in the same cycle: the done-driven clear and a new grant to a different thread both take effect. A thread is never re-granted in the cycle its done arrives.
- Boundary conditions:
  - thread_done for a thread whose active_mask bit is 0: ignored.
  - start while busy=1: ignored; job_count is not resampled.
  - thread_start is all-zero in any cycle without a grant; thread_job holds its last value.
  - jobs_issued never exceeds job_count.
  - Full JOB_W range supported: job_count = 2^JOB_W−1 issues IDs 0..2^JOB_W−2.
  - frame_done asserts exactly once per accepted start. busy drops to 0 in the cycle after frame_done.

Test Plan:
1. rst, then start with job_count=4; each thread pulses done 3 cycles after its start:
   - thread_start bits 0,1,2,3 in cycles t+2..t+5 with thread_job 0..3.
   - frame_done once after the last done; busy low the cycle after.
2. job_count=20 and no dones:
   - Threads 0..15 receive jobs 0..15, then grants stall with jobs_issued=16.
   - Pulse thread_done[5] → thread 5 gets job 16 two cycles later (pointer wrapped to 0, first idle is 5).
   - Pulse thread_done[2] and thread_done[9] in the same cycle → jobs 17 and 18 go to threads 9 and 2 on consecutive cycles (pointer is 6 after the job-16 grant, so 9 is found first).
3. job_count=0 → no thread_start; frame_done pulses; busy high for exactly 2 cycles.
4. Assert rst during DISPATCH with 7 jobs issued:
   - All outputs return to 0 the next cycle.
   - Subsequent thread_done pulses cause no change.
   - A new start with job_count=3 dispatches jobs 0..2 to threads 0..2.
5. Spurious events:
   - thread_done[12] while thread 12 is idle → active_mask unchanged.
   - start with job_count=99 mid-frame → ignored; the frame completes with the original count.
